// File: rtl/cdb_result_buffer.sv
// CDB result buffer: per-FU writeback queue in front of the CDB arbiter.
// Holds finished results in a small FIFO, requests a CDB port while non-empty,
// pops the head on grant and back-pressures the FU when full. head_age tells
// the arbiter how long the current head has been waiting.
module cdb_result_buffer #(
    parameter int unsigned DEPTH = 2,   // power of 2, >= 2
    parameter int unsigned AGE_W = 4,   // saturating head-wait counter width
    parameter int unsigned PKT_W = 32   // $bits(writeback_packet_t)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       fu_valid,
    input  logic [PKT_W-1:0]           fu_packet,
    output logic                       fu_ready,
    output logic                       cdb_req,
    output logic [PKT_W-1:0]           cdb_packet,
    input  logic                       cdb_gnt,
    output logic [AGE_W-1:0]           head_age,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             push, pop;

    // Outputs come from registered state only: no fu_valid->cdb_req bypass and
    // no cdb_gnt->fu_ready path, so a full buffer refuses a push even on a pop.
    always_comb begin
        fu_ready   = (count_q < CNT_W'(DEPTH));
        cdb_req    = (count_q != '0);
        cdb_packet = cdb_req ? mem[rd_ptr_q] : '0;
        head_age   = age_q;
        occupancy  = count_q;
        push       = fu_valid & fu_ready;
        pop        = cdb_req & cdb_gnt;
    end

    // Next-state for pointers, count and head age; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        age_d    = age_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            age_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            // A new head (after pop) or an empty buffer restarts the age at 0.
            if (pop || !cdb_req) begin
                age_d = '0;
            end else if (age_q != AGE_MAX) begin
                age_d = age_q + AGE_W'(1);
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
        end
    end

    // Storage array, deliberately not reset; a flushed push is never written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= fu_packet;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == '0));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(cdb_gnt && !cdb_req));
    a_idle_packet_zero: assert property (@(posedge clk) disable iff (!rst_n)
        cdb_req || cdb_packet == '0);

endmodule
